// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The round-robin option is selected by the DMEM_ARB_RR_EN macro.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int PORT_CORE      = 0;
  localparam int PORT_DBG       = 1;
  localparam int RD_LATENCY_MAX = 4;

  // Latency counter width: $clog2 of the latency, never less than one bit
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Two-port combinational winner selection.
// DMEM_ARB_RR_EN defined: on contention the port other than last_win wins.
// DMEM_ARB_RR_EN absent: port 0 always wins on contention; last_win ignored.
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  output logic [1:0] win
);

`ifdef DMEM_ARB_RR_EN
  // Contention resolves away from the previous winner
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last_win ? 2'b01 : 2'b10;
    end
  end
`else
  logic w_unused_last_win;
  assign w_unused_last_win = last_win;

  // Port 0 has fixed priority
  always_comb begin
    win = 2'b00;
    if (req[PORT_CORE]) begin
      win = 2'b01;
    end else if (req[PORT_DBG]) begin
      win = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core (port 0) and the
// debug/loader master (port 1). Stores complete in the grant cycle; loads
// hold address and funct3 on the memory port until the data returns
// RD_LATENCY cycles later with a one-cycle rvalid pulse.
// Optional round-robin arbitration: define DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  f3_0,
  input  logic [2:0]  f3_1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_wren,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_data_out
);

  localparam int CNT_W = cnt_width(RD_LATENCY);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr_q;
  logic [2:0]       r_f3_q;
  logic             r_owner_q;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;

  logic             w_last_win;
  logic [1:0]       w_win;
  logic [1:0]       w_gnt;
  logic             w_sel;
  logic             w_sel_we;
  logic [31:0]      w_sel_addr;
  logic [31:0]      w_sel_wdata;
  logic [2:0]       w_sel_f3;

  arb_pick2 u_pick (
    .req      (req),
    .last_win (w_last_win),
    .win      (w_win)
  );

  assign w_gnt       = (r_state == IDLE) ? w_win : 2'b00;
  assign w_sel       = w_win[PORT_DBG];
  assign w_sel_we    = w_sel ? we[PORT_DBG] : we[PORT_CORE];
  assign w_sel_addr  = w_sel ? addr1  : addr0;
  assign w_sel_wdata = w_sel ? wdata1 : wdata0;
  assign w_sel_f3    = w_sel ? f3_1   : f3_0;

`ifdef DMEM_ARB_RR_EN
  logic r_last_win;

  // Remember the most recent winner; starts at 1 so port 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_win <= 1'b1;
    end else if (w_gnt != 2'b00) begin
      r_last_win <= w_sel;
    end
  end

  assign w_last_win = r_last_win;
`else
  assign w_last_win = 1'b1;
`endif

  // Memory port: winner in an accepting IDLE cycle, held load otherwise
  always_comb begin
    gnt         = w_gnt;
    mem_wren    = 1'b0;
    mem_address = 32'd0;
    mem_data_in = 32'd0;
    mem_funct3  = 3'd0;
    if (r_state == IDLE) begin
      if (w_gnt != 2'b00) begin
        mem_wren    = w_sel_we;
        mem_address = w_sel_addr;
        mem_data_in = w_sel_wdata;
        mem_funct3  = w_sel_f3;
      end
    end else begin
      // memory applies funct3 to its output, so it stays driven through RESP
      mem_address = r_addr_q;
      mem_funct3  = r_f3_q;
    end
  end

  // Load return: pulse plus bypass so rdata is valid alongside rvalid
  always_comb begin
    rvalid = 2'b00;
    rdata0 = r_rdata0;
    rdata1 = r_rdata1;
    if (r_state == RESP) begin
      if (r_owner_q) begin
        rvalid = 2'b10;
        rdata1 = mem_data_out;
      end else begin
        rvalid = 2'b01;
        rdata0 = mem_data_out;
      end
    end
  end

  // Transaction FSM: capture loads, count latency, deliver data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr_q  <= 32'd0;
      r_f3_q    <= 3'd0;
      r_owner_q <= 1'b0;
      r_rdata0  <= 32'd0;
      r_rdata1  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((w_gnt != 2'b00) && !w_sel_we) begin
            r_addr_q  <= w_sel_addr;
            r_f3_q    <= w_sel_f3;
            r_owner_q <= w_sel;
            r_cnt     <= CNT_W'(RD_LATENCY - 1);
            r_state   <= (RD_LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (r_owner_q) begin
            r_rdata1 <= mem_data_out;
          end else begin
            r_rdata0 <= mem_data_out;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level reference model.
// Honours DMEM_ARB_RR_EN for the expected arbitration order.
module tb_dmem_arbiter;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  f3_0, f3_1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata0, rdata1;
  logic        mem_wren;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .f3_0(f3_0), .f3_1(f3_1), .gnt(gnt), .rvalid(rvalid),
    .rdata0(rdata0), .rdata1(rdata1), .mem_wren(mem_wren),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
  );

  // ---------------- memory device (driven by the DUT) ----------------
  bit   [7:0]  dev_mem [0:255];
  bit   [7:0]  ref_mem [0:255];
  logic [31:0] pipe [0:L-1];

  function automatic logic [31:0] shape(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dev_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {dev_mem[b + 8'd3], dev_mem[b + 8'd2], dev_mem[b + 8'd1], dev_mem[b]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= shape(mem_funct3, mem_address[1:0], dev_word(mem_address));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    if (mem_wren === 1'b1) begin
      dev_mem[mem_address[7:0]] <= mem_data_in[7:0];
      if (mem_funct3[1:0] != 2'b00) dev_mem[mem_address[7:0] + 8'd1] <= mem_data_in[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        dev_mem[mem_address[7:0] + 8'd2] <= mem_data_in[23:16];
        dev_mem[mem_address[7:0] + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  assign mem_data_out = pipe[L-1];

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } acc_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } rv_t;

  acc_t        pq [2][$];
  rv_t         rvq[$];
  int          og [2][$];
  int          orv[2][$];
  logic [1:0]  gseq[$];
  int          cyc, next_free;
  logic        last_win;
  logic [31:0] m_rd [2];
  logic [31:0] hold_addr;
  logic [2:0]  hold_f3;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [1:0] p);
    if (p == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      return (last_win == 1'b0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return p[1] ? 1 : 0;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    ref_mem[a[7:0]] = d[7:0];
    if (f3[1:0] != 2'b00) ref_mem[a[7:0] + 8'd1] = d[15:8];
    if (f3[1:0] == 2'b10) begin
      ref_mem[a[7:0] + 8'd2] = d[23:16];
      ref_mem[a[7:0] + 8'd3] = d[31:24];
    end
  endtask

  task automatic push(input int p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3);
    acc_t t;
    t.we = w; t.addr = a; t.wdata = d; t.f3 = f3;
    pq[p].push_back(t);
  endtask

  task automatic clear_logs();
    for (int p = 0; p < 2; p++) begin
      og[p].delete();
      orv[p].delete();
    end
    gseq.delete();
  endtask

  // One clock: present requests, compare all outputs, then advance the model
  task automatic cycle(input bit rst_now);
    logic [1:0]  pend, e_gnt, e_rv;
    logic        e_wren;
    logic [31:0] e_addr, e_din;
    logic [2:0]  e_f3;
    int          win;
    bit          free;
    acc_t        a;
    rv_t         r;
    @(negedge clk);
    reset = rst_now;
    pend[0] = (pq[0].size() != 0);
    pend[1] = (pq[1].size() != 0);
    req    = pend;
    we     = {pend[1] ? pq[1][0].we    : 1'b0,  pend[0] ? pq[0][0].we    : 1'b0};
    addr0  = pend[0] ? pq[0][0].addr  : 32'd0;
    addr1  = pend[1] ? pq[1][0].addr  : 32'd0;
    wdata0 = pend[0] ? pq[0][0].wdata : 32'd0;
    wdata1 = pend[1] ? pq[1][0].wdata : 32'd0;
    f3_0   = pend[0] ? pq[0][0].f3    : 3'd0;
    f3_1   = pend[1] ? pq[1][0].f3    : 3'd0;
    #1;
    free = (cyc >= next_free);
    win = -1;
    e_gnt = 2'b00; e_wren = 1'b0; e_addr = 32'd0; e_din = 32'd0; e_f3 = 3'd0;
    if (free && pend != 2'b00) begin
      win = model_pick(pend);
      a = pq[win][0];
      e_gnt = (win == 1) ? 2'b10 : 2'b01;
      e_wren = a.we; e_addr = a.addr; e_din = a.wdata; e_f3 = a.f3;
    end else if (!free) begin
      e_addr = hold_addr; e_f3 = hold_f3;
    end
    e_rv = 2'b00;
    if (rvq.size() != 0 && rvq[0].cyc == cyc) begin
      r = rvq.pop_front();
      e_rv = (r.port == 1) ? 2'b10 : 2'b01;
      m_rd[r.port] = r.data;
    end
    chk("gnt",      32'(gnt),        32'(e_gnt));
    chk("rvalid",   32'(rvalid),     32'(e_rv));
    chk("mem_wren", 32'(mem_wren),   32'(e_wren));
    chk("mem_addr", mem_address,     e_addr);
    chk("mem_f3",   32'(mem_funct3), 32'(e_f3));
    if (free) chk("mem_din", mem_data_in, e_din);
    chk("rdata0",   rdata0,          m_rd[0]);
    chk("rdata1",   rdata1,          m_rd[1]);
    if (gnt[0] === 1'b1) og[0].push_back(cyc);
    if (gnt[1] === 1'b1) og[1].push_back(cyc);
    if (rvalid[0] === 1'b1) orv[0].push_back(cyc);
    if (rvalid[1] === 1'b1) orv[1].push_back(cyc);
    if (gnt !== 2'b00) gseq.push_back(gnt);
    @(posedge clk);
    if (rst_now) begin
      next_free = 0;
      rvq.delete();
      m_rd[0] = 32'd0; m_rd[1] = 32'd0;
      last_win = 1'b1;
    end else if (win >= 0) begin
      void'(pq[win].pop_front());
      last_win = (win == 1);
      if (a.we) begin
        ref_store(a.addr, a.wdata, a.f3);
      end else begin
        r.cyc = cyc + L; r.port = win;
        r.data = shape(a.f3, a.addr[1:0], ref_word(a.addr));
        rvq.push_back(r);
        next_free = cyc + L + 1;
        hold_addr = a.addr; hold_f3 = a.f3;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pq[0].size() != 0 || pq[1].size() != 0 || rvq.size() != 0 || cyc < next_free)
           && n < 300) begin
      cycle(1'b0);
      n++;
    end
    chk("drain_bound", 32'(n < 300), 32'd1);
  endtask

  function automatic acc_t rnd_acc();
    acc_t t;
    logic [2:0] w;
    t.we = 1'($urandom_range(0, 1));
    w = 3'($urandom_range(0, 2));
    t.f3 = (!t.we && $urandom_range(0, 1) == 1 && w != 3'd2) ? (w | 3'b100) : w;
    t.addr = 32'h2000 + 32'($urandom_range(0, 63));
    if (w == 3'd1) t.addr[0] = 1'b0;
    if (w == 3'd2) t.addr[1:0] = 2'b00;
    t.wdata = $urandom;
    return t;
  endfunction

  logic [1:0] exp_seq [4];

  initial begin
    n_vec = 0; n_err = 0;
    cyc = 0; next_free = 0; last_win = 1'b1;
    m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    hold_addr = 32'd0; hold_f3 = 3'd0;
    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    f3_0 = 3'd0; f3_1 = 3'd0;
    repeat (3) @(posedge clk);

    // reset state, idle with no request
    cycle(1'b0);

    // port-0 store then load of the same word
    clear_logs();
    push(0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b010);
    drain();
    push(0, 1'b0, 32'h0000_2000, 32'd0, 3'b010);
    drain();
    chk("t1_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("t1_latency", 32'(orv[0].size() == 1 ? orv[0][0] - og[0][1] : -1), 32'(L));

    // simultaneous single loads right after reset
    cycle(1'b1);
    clear_logs();
    push(0, 1'b0, 32'h0000_2000, 32'd0, 3'b010);
    push(1, 1'b0, 32'h0000_2004, 32'd0, 3'b010);
    drain();
    chk("t2_gap", 32'((og[0].size() == 1 && og[1].size() == 1) ? og[1][0] - og[0][0] : -1),
        32'(L + 1));

    // sustained contention: port 0 issues three loads, port 1 one
    clear_logs();
    for (int k = 0; k < 3; k++) push(0, 1'b0, 32'h0000_2000 + 32'(4 * k), 32'd0, 3'b010);
    push(1, 1'b0, 32'h0000_2008, 32'd0, 3'b010);
    drain();
`ifdef DMEM_ARB_RR_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`endif
    chk("t2_seq_len", 32'(gseq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_seq%0d", k), 32'(k < gseq.size() ? gseq[k] : 2'b00), 32'(exp_seq[k]));

    // four back-to-back port-1 stores
    clear_logs();
    for (int k = 0; k < 4; k++) push(1, 1'b1, 32'h0000_2020 + 32'(4 * k), $urandom, 3'b010);
    drain();
    chk("t3_count", 32'(og[1].size()), 32'd4);
    chk("t3_span", 32'(og[1].size() == 4 ? og[1][3] - og[1][0] : -1), 32'd3);

    // signed byte load of 0x80
    clear_logs();
    push(0, 1'b1, 32'h0000_2011, 32'h0000_0080, 3'b000);
    push(0, 1'b0, 32'h0000_2011, 32'd0, 3'b000);
    drain();
    chk("t4_lb", rdata0, 32'hFFFF_FF80);

    // reset in the WAIT cycle of a load
    clear_logs();
    push(0, 1'b0, 32'h0000_2000, 32'd0, 3'b010);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    push(1, 1'b1, 32'h0000_2030, 32'h1234_5678, 3'b010);
    cycle(1'b0);
    chk("t5_regrant", 32'(og[1].size()), 32'd1);
    drain();
    chk("t5_no_rvalid", 32'(orv[0].size()), 32'd0);

    // port 1 requests during port 0's WAIT
    clear_logs();
    push(0, 1'b0, 32'h0000_2000, 32'd0, 3'b010);
    cycle(1'b0);
    push(1, 1'b0, 32'h0000_2011, 32'd0, 3'b000);
    drain();
    chk("t6_g1_after_rv0",
        32'((og[1].size() == 1 && orv[0].size() == 1) ? og[1][0] - orv[0][0] : -1), 32'd1);
    chk("t6_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("t6_rdata1", rdata1, 32'hFFFF_FF80);

    // random traffic on both ports
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++)
        if (pq[p].size() == 0 && $urandom_range(0, 2) != 0) pq[p].push_back(rnd_acc());
      cycle(1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port of the `memory` block between two requesters: the processor core (port 0) and a debug/loader master (port 1). It grants one access at a time, drives the memory's `dmem_*` and `funct3` inputs from the winner, and holds the read address and width stable across the memory's registered read latency. It returns load data to the owning requester with a one-cycle `rvalid` pulse. It sits between the core datapath and `memory`, replacing the direct `alu_out_reg`/`reg_b`/`funct3` wiring.

## Interface
- `RD_LATENCY`, 1: cycles from the address being presented to `mem_data_out` being valid; legal range 1–4.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 2: access request; bit 0 is the core, bit 1 is debug.
- `we` in 2: per-port write enable; 1 = store, 0 = load.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: store data.
- `f3_0`, `f3_1` in 3: RV32I load/store `funct3` (width/sign).
- `gnt` out 2: one-hot; the access is accepted this cycle.
- `rvalid` out 2: one-hot, one-cycle load-data-valid pulse.
- `rdata0`, `rdata1` out 32: load data; each holds its value until that port's next `rvalid`.
- `mem_wren` out 1: to `memory.dmem_wren`.
- `mem_address` out 32: to `memory.dmem_address`.
- `mem_data_in` out 32: to `memory.dmem_data_in`.
- `mem_funct3` out 3: to `memory.funct3`.
- `mem_data_out` in 32: from `memory.dmem_data_out`.

## Operation
- States:
  - IDLE accepts new requests.
  - WAIT counts read latency.
  - RESP delivers load data.
- IDLE with no `req`:
  - `gnt`=0 and `mem_wren`=0.
  - `mem_address`, `mem_data_in` and `mem_funct3` are 0.
- IDLE with any `req`:
  - The winner is picked combinationally.
  - The winner's signals are muxed onto the memory port.
  - `gnt[winner]`=1 in the same cycle.
- Granted store:
  - `mem_wren`=1 for exactly that cycle.
  - State stays IDLE, so back-to-back stores are allowed, one per cycle.
- Granted load:
  - Register `addr_q`, `f3_q` and `owner_q`.
  - Load `cnt`=RD_LATENCY−1.
  - Go to WAIT, or directly to RESP if RD_LATENCY=1.
- WAIT:
  - `mem_address`=`addr_q`, `mem_funct3`=`f3_q`, `mem_wren`=0, `gnt`=0.
  - `cnt` decrements each cycle; at 0, go to RESP.
- RESP:
  - The memory port still drives `addr_q`/`f3_q`, because `memory` applies `funct3` sign/width to its output.
  - `rdata[owner_q]`<=`mem_data_out`; `rvalid[owner_q]`=1.
  - `gnt`=0; next state is IDLE.
- Requester contract:
  - Hold `req`, `we`, address, data and `f3` stable until `gnt`.
  - The arbiter never drops a pending request.
  - A requester deasserts `req` or presents its next access the cycle after `gnt`.
- Fixed-priority mode (macro absent): port 0 always wins when both ports request.
- Simultaneous events:
  - A request arriving during WAIT/RESP waits; it is not lost.
  - A port may re-request in the RESP cycle; it is evaluated in the following IDLE cycle.

## Timing
- Reset values:
  - state=IDLE; `gnt`, `rvalid`, `rdata0`, `rdata1` and `mem_wren` are 0.
  - `addr_q`, `f3_q`, `owner_q` and `cnt` are 0; `last_win`=1, so port 0 wins first under round-robin.
- Store latency: `gnt` and `mem_wren` fall in the same cycle N; the memory write occurs at edge N→N+1.
- Load:
  - `gnt` is in cycle N; `rvalid` is in cycle N+RD_LATENCY.
  - The next grant can happen no earlier than cycle N+RD_LATENCY+1.
- Reset asserted mid-load: the transaction is abandoned, no `rvalid` is produced, and the state is IDLE on the next cycle.
- `cnt` width is `$clog2(RD_LATENCY)` with a minimum of 1 bit; it never wraps because it is reloaded only in IDLE.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - On contention, the port ≠ `last_win` wins.
  - `last_win` updates on every grant, including uncontended ones.
- `DMEM_ARB_RR_EN` absent:
  - Fixed priority, port 0 wins.
  - `last_win` is not implemented.

## Structure
- Package `dmem_arb_pkg`:
  - State enum `arb_state_t` {IDLE, WAIT, RESP}.
  - Port-index constants `PORT_CORE`=0 and `PORT_DBG`=1.
  - `RD_LATENCY_MAX`=4.
- Sub-module `arb_pick2`:
  - Inputs: `req[1:0]` and `last_win`.
  - Outputs: one-hot `win[1:0]`.
  - Purely combinational; honours `DMEM_ARB_RR_EN`.

## Test plan
- Reset, then a port-0 store to 0x0000_2000 with data 0xDEAD_BEEF and `f3`=010 → `gnt`=01 and `mem_wren`=1 in the same cycle; a later port-0 load from 0x2000 returns 0xDEAD_BEEF with `rvalid`=01 exactly RD_LATENCY cycles after `gnt`.
- Both ports request loads in the same cycle:
  - Without the macro → port 0 is granted first; port 1 is granted RD_LATENCY+1 cycles later.
  - With `DMEM_ARB_RR_EN` → grants alternate 01,10,01 over three contended rounds.
- Four back-to-back port-1 stores → four consecutive `gnt` cycles with `mem_wren`=1 and no idle gaps.
- RD_LATENCY=3, port-0 `lb` (`f3`=000) of byte 0x80 → `mem_address`/`mem_funct3` are held for 4 cycles; `rdata0`=0xFFFF_FF80.
- Assert `reset` in the WAIT cycle of a load → no `rvalid`, all outputs are 0 next cycle, and a new request is granted immediately after.
- Port 1 requests during port 0's WAIT → `gnt[1]` is 0 until the cycle after port 0's `rvalid`, then 1; `rdata0` is unchanged by port 1's load.
